// File: rtl/ex_mem_skid_pkg.sv
// Shared types and defaults for the EX/MEM skid-buffered pipeline register.
package ex_mem_skid_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_CNT_W      = 16;

  // Encoding is chosen so that the state value equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(input state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/ex_mem_skid_if.sv
// Valid/ready channel carrying one EX/MEM entry (write-back + memory-access fields).
interface ex_mem_skid_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
);
  logic                  valid;
  logic                  ready;
  logic [DATA_W-1:0]     wData;
  logic                  wReg;
  logic [REG_ADDR_W-1:0] wRegAddr;
  logic                  memRead;
  logic                  memWrite;
  logic [DATA_W-1:0]     memAddr;

  modport master (output valid, wData, wReg, wRegAddr, memRead, memWrite, memAddr,
                  input  ready);
  modport slave  (input  valid, wData, wReg, wRegAddr, memRead, memWrite, memAddr,
                  output ready);
endinterface

// File: rtl/ex_mem_skid_slot.sv
// One payload register bundle with load enable; used as both main and skid slot.
module ex_mem_slot
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_W-1:0]     wData_i,
  input  logic                  wReg_i,
  input  logic [REG_ADDR_W-1:0] wRegAddr_i,
  input  logic                  memRead_i,
  input  logic                  memWrite_i,
  input  logic [DATA_W-1:0]     memAddr_i,
  output logic [DATA_W-1:0]     wData_o,
  output logic                  wReg_o,
  output logic [REG_ADDR_W-1:0] wRegAddr_o,
  output logic                  memRead_o,
  output logic                  memWrite_o,
  output logic [DATA_W-1:0]     memAddr_o
);

  logic [DATA_W-1:0]     wData_q;
  logic                  wReg_q;
  logic [REG_ADDR_W-1:0] wRegAddr_q;
  logic                  memRead_q;
  logic                  memWrite_q;
  logic [DATA_W-1:0]     memAddr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wData_q    <= '0;
      wReg_q     <= 1'b0;
      wRegAddr_q <= '0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memAddr_q  <= '0;
    end else if (load_i) begin
      wData_q    <= wData_i;
      wReg_q     <= wReg_i;
      wRegAddr_q <= wRegAddr_i;
      memRead_q  <= memRead_i;
      memWrite_q <= memWrite_i;
      memAddr_q  <= memAddr_i;
    end
  end

  assign wData_o    = wData_q;
  assign wReg_o     = wReg_q;
  assign wRegAddr_o = wRegAddr_q;
  assign memRead_o  = memRead_q;
  assign memWrite_o = memWrite_q;
  assign memAddr_o  = memAddr_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with valid/ready on both sides, 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
//   state    | meaning
//   ST_EMPTY | nothing held, in_ready=1
//   ST_FULL  | main slot valid, in_ready=1
//   ST_SKID  | main and skid slots valid, in_ready=0
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  ex_mem_skid_if.slave      ex_i,
  ex_mem_skid_if.master     mem_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stallCnt_o
);

  state_e                state_q, state_d;
  logic                  ready_q;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  do_accept, do_release, out_valid;
  logic                  load_main, load_skid, main_from_skid;

  logic [DATA_W-1:0]     mi_wData, m_wData, s_wData, m_memAddr, s_memAddr, mi_memAddr;
  logic [REG_ADDR_W-1:0] mi_wRegAddr, m_wRegAddr, s_wRegAddr;
  logic                  mi_wReg, m_wReg, s_wReg;
  logic                  mi_memRead, m_memRead, s_memRead;
  logic                  mi_memWrite, m_memWrite, s_memWrite;

  assign out_valid  = (state_q != ST_EMPTY);
  assign do_accept  = ex_i.valid & ready_q;
  assign do_release = out_valid & mem_o.ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (do_accept) begin
          load_main = 1'b1;
          state_d   = ST_FULL;
        end
        ST_FULL: begin
          if (do_accept && do_release) begin
            load_main = 1'b1;
          end else if (do_accept) begin
            load_skid = 1'b1;
            state_d   = ST_SKID;
          end else if (do_release) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: if (do_release) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Counter ignores flush so squashes do not hide back-pressure history.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ex_i.valid && !ready_q && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      ready_q     <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d != ST_SKID);
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mi_wData    = main_from_skid ? s_wData    : ex_i.wData;
  assign mi_wReg     = main_from_skid ? s_wReg     : ex_i.wReg;
  assign mi_wRegAddr = main_from_skid ? s_wRegAddr : ex_i.wRegAddr;
  assign mi_memRead  = main_from_skid ? s_memRead  : ex_i.memRead;
  assign mi_memWrite = main_from_skid ? s_memWrite : ex_i.memWrite;
  assign mi_memAddr  = main_from_skid ? s_memAddr  : ex_i.memAddr;

  ex_mem_slot #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_main (
    .clk(clk), .rst(rst), .load_i(load_main),
    .wData_i(mi_wData), .wReg_i(mi_wReg), .wRegAddr_i(mi_wRegAddr),
    .memRead_i(mi_memRead), .memWrite_i(mi_memWrite), .memAddr_i(mi_memAddr),
    .wData_o(m_wData), .wReg_o(m_wReg), .wRegAddr_o(m_wRegAddr),
    .memRead_o(m_memRead), .memWrite_o(m_memWrite), .memAddr_o(m_memAddr)
  );

  ex_mem_slot #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_skid (
    .clk(clk), .rst(rst), .load_i(load_skid),
    .wData_i(ex_i.wData), .wReg_i(ex_i.wReg), .wRegAddr_i(ex_i.wRegAddr),
    .memRead_i(ex_i.memRead), .memWrite_i(ex_i.memWrite), .memAddr_i(ex_i.memAddr),
    .wData_o(s_wData), .wReg_o(s_wReg), .wRegAddr_o(s_wRegAddr),
    .memRead_o(s_memRead), .memWrite_o(s_memWrite), .memAddr_o(s_memAddr)
  );

  assign ex_i.ready     = ready_q;
  assign mem_o.valid    = out_valid;
  assign mem_o.wData    = m_wData;
  assign mem_o.wRegAddr = m_wRegAddr;
  assign mem_o.memAddr  = m_memAddr;
  assign mem_o.wReg     = m_wReg & out_valid;
  assign mem_o.memRead  = m_memRead & out_valid;
  assign mem_o.memWrite = m_memWrite & out_valid;
  assign occupancy_o    = occ_of(state_q);
  assign stallCnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Randomized bench for ex_mem_skid against a queue-based reference model.
module tb_ex_mem_skid;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] wData;
    logic          wReg;
    logic [AW-1:0] wRegAddr;
    logic          memRead;
    logic          memWrite;
    logic [DW-1:0] memAddr;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [1:0]    occ;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  ex_mem_skid_if #(.DATA_W(DW), .REG_ADDR_W(AW)) ex_if ();
  ex_mem_skid_if #(.DATA_W(DW), .REG_ADDR_W(AW)) mem_if ();

  ex_mem_skid #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .ex_i(ex_if), .mem_o(mem_if),
    .occupancy_o(occ), .stallCnt_o(cnt)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q[$];
  ent_t last_head;
  bit   rdy_m;
  int   cnt_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [DW-1:0] d);
    ent_t e;
    e.wData    = d;
    e.wReg     = 1'($urandom);
    e.wRegAddr = AW'($urandom);
    e.memRead  = 1'($urandom);
    e.memWrite = 1'($urandom);
    e.memAddr  = DW'($urandom);
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    last_head = '0;
    rdy_m     = 1'b1;
    cnt_m     = 0;
  endtask

  task automatic model_step(input ent_t e, input bit v, input bit ordy, input bit fl);
    bit acc, rel;
    acc = v && rdy_m;
    rel = (q.size() > 0) && ordy;
    if (v && !rdy_m && cnt_m < (1 << CW) - 1) cnt_m++;
    if (fl) q.delete();
    else begin
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last_head = q[0];
    rdy_m = (q.size() < 2);
  endtask

  task automatic check_outputs();
    ent_t h;
    bit   v;
    v = (q.size() > 0);
    h = v ? q[0] : last_head;
    chk("out_valid", 32'(mem_if.valid), 32'(v));
    chk("in_ready",  32'(ex_if.ready),  32'(rdy_m));
    chk("occupancy", 32'(occ),          32'(q.size()));
    chk("stall_cnt", 32'(cnt),          32'(cnt_m));
    chk("wData",     32'(mem_if.wData),    32'(h.wData));
    chk("wRegAddr",  32'(mem_if.wRegAddr), 32'(h.wRegAddr));
    chk("memAddr",   32'(mem_if.memAddr),  32'(h.memAddr));
    chk("wReg",      32'(mem_if.wReg),     32'(v & h.wReg));
    chk("memRead",   32'(mem_if.memRead),  32'(v & h.memRead));
    chk("memWrite",  32'(mem_if.memWrite), 32'(v & h.memWrite));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(mem_if.valid),    32'd0);
    chk({tag, "_ready"}, 32'(ex_if.ready),     32'd1);
    chk({tag, "_occ"},   32'(occ),             32'd0);
    chk({tag, "_cnt"},   32'(cnt),             32'd0);
    chk({tag, "_wData"}, 32'(mem_if.wData),    32'd0);
    chk({tag, "_wReg"},  32'(mem_if.wReg),     32'd0);
    chk({tag, "_waddr"}, 32'(mem_if.wRegAddr), 32'd0);
    chk({tag, "_mrd"},   32'(mem_if.memRead),  32'd0);
    chk({tag, "_mwr"},   32'(mem_if.memWrite), 32'd0);
    chk({tag, "_maddr"}, 32'(mem_if.memAddr),  32'd0);
  endtask

  task automatic drive(input ent_t e, input bit v, input bit ordy, input bit fl);
    ex_if.valid    = v;
    ex_if.wData    = e.wData;
    ex_if.wReg     = e.wReg;
    ex_if.wRegAddr = e.wRegAddr;
    ex_if.memRead  = e.memRead;
    ex_if.memWrite = e.memWrite;
    ex_if.memAddr  = e.memAddr;
    mem_if.ready   = ordy;
    flush          = fl;
  endtask

  task automatic step(input ent_t e, input bit v, input bit ordy, input bit fl);
    drive(e, v, ordy, fl);
    @(posedge clk);
    model_step(e, v, ordy, fl);
    @(negedge clk);
    check_outputs();
  endtask

  ent_t fe;

  initial begin
    model_reset();
    drive('0, 1'b0, 1'b0, 1'b0);
    #12;
    check_reset_state("rst0");
    #1 rst = 1'b0;
    @(negedge clk);

    // streaming with MEM always ready
    for (int i = 1; i <= 4; i++) step(mk(DW'(i)), 1'b1, 1'b1, 1'b0);
    step(mk(16'h0), 1'b0, 1'b1, 1'b0);

    // back-pressure then drain
    step(mk(16'hAAAA), 1'b1, 1'b0, 1'b0);
    step(mk(16'hBBBB), 1'b1, 1'b0, 1'b0);
    chk("bp_ready_low", 32'(ex_if.ready), 32'd0);
    fe = mk(16'hCCCC);
    repeat (3) step(fe, 1'b1, 1'b0, 1'b0);
    chk("bp_occ2", 32'(occ), 32'd2);
    repeat (2) step(fe, 1'b1, 1'b1, 1'b0);
    repeat (2) step(mk(16'h0), 1'b0, 1'b1, 1'b0);

    // flush at occupancy 2 with a live input
    step(mk(16'h1111), 1'b1, 1'b0, 1'b0);
    step(mk(16'h2222), 1'b1, 1'b0, 1'b0);
    fe = mk(16'hDEAD);
    fe.wReg = 1'b1;
    fe.memWrite = 1'b1;
    step(fe, 1'b1, 1'b0, 1'b1);
    chk("flush_occ",   32'(occ),             32'd0);
    chk("flush_valid", 32'(mem_if.valid),    32'd0);
    chk("flush_wreg",  32'(mem_if.wReg),     32'd0);
    chk("flush_mwr",   32'(mem_if.memWrite), 32'd0);
    chk("flush_ready", 32'(ex_if.ready),     32'd1);
    repeat (2) step(mk(16'h0), 1'b0, 1'b1, 1'b0);

    // randomized traffic
    repeat (400) begin
      step(mk(DW'($urandom)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    // asynchronous reset mid-operation
    step(mk(16'h5555), 1'b1, 1'b0, 1'b0);
    step(mk(16'h6666), 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_state("rst_mid");
    drive('0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);

    // saturation of the stall counter
    repeat (22) step(mk(DW'($urandom)), 1'b1, 1'b0, 1'b0);
    chk("sat_cnt", 32'(cnt), 32'hF);
    repeat (3) step(mk(DW'($urandom)), 1'b1, 1'b0, 1'b0);
    chk("sat_hold", 32'(cnt), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
